// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared scheduler constants and types.
//   SCHED_ROWS    - default number of scheduler entries (dependency-matrix rows)
//   sched_row_t   - row index type for the default configuration
//   sched_state_t - scheduler control FSM states {RUN, FLUSH}
package issue_scheduler_pkg;

    localparam int SCHED_ROWS = 8;

    typedef logic [$clog2(SCHED_ROWS)-1:0] sched_row_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

endpackage

// File: rtl/issue_scheduler_dep_matrix.sv
// issue_scheduler_dep_matrix: NUM_ROWS x NUM_ROWS dependency matrix.
// Bit [r][c] set means the op in row r waits on the op in row c.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   w_en/w_row      - overwrite row w_row with set_lines
//   set_lines       - producer rows the newly written row depends on
//   clear_en        - clear columns selected by clear_lines in every row
//   clear_lines     - column mask to clear (completed producers)
//   free_en         - zero row free_row_index
//   free_row_index  - row to zero
//   ready_vector    - per row: no outstanding dependency
module issue_scheduler_dep_matrix
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_ROWS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    input  logic [$clog2(NUM_ROWS)-1:0] w_row,
    input  logic [NUM_ROWS-1:0]         set_lines,
    input  logic                        clear_en,
    input  logic [NUM_ROWS-1:0]         clear_lines,
    input  logic                        free_en,
    input  logic [$clog2(NUM_ROWS)-1:0] free_row_index,
    output logic [NUM_ROWS-1:0]         ready_vector
);

    localparam int ROW_W = $clog2(NUM_ROWS);

    logic [NUM_ROWS-1:0] dep_r     [NUM_ROWS];
    logic [NUM_ROWS-1:0] dep_nxt_s [NUM_ROWS];

    // Next matrix contents: column clear, then row free, then row write (write wins).
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            dep_nxt_s[r] = dep_r[r];
            if (clear_en) begin
                dep_nxt_s[r] = dep_nxt_s[r] & ~clear_lines;
            end else begin
                dep_nxt_s[r] = dep_nxt_s[r];
            end
            if (free_en && (free_row_index == ROW_W'(r))) begin
                dep_nxt_s[r] = '0;
            end else begin
                dep_nxt_s[r] = dep_nxt_s[r];
            end
            if (w_en && (w_row == ROW_W'(r))) begin
                dep_nxt_s[r] = set_lines;
            end else begin
                dep_nxt_s[r] = dep_nxt_s[r];
            end
        end
    end

    // Matrix storage.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (rst) begin
                dep_r[r] <= '0;
            end else begin
                dep_r[r] <= dep_nxt_s[r];
            end
        end
    end

    // A row is ready once every producer it waited on has been cleared.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            ready_vector[r] = ~|dep_r[r];
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: allocates scheduler rows to dispatched ops, tracks their
// dependencies in a dependency matrix and issues one ready op at a time.
// Optional build macro: SCHED_AGE_PRIORITY_EN - oldest eligible row is
// selected (4-bit saturating per-row age, ties to lowest index); otherwise
// the lowest-index eligible row is selected.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   disp_valid     - dispatch request; disp_ready - dispatch accepted
//   disp_src_mask  - rows the dispatched op depends on
//   disp_row       - row allocated to the dispatched op (lowest free row)
//   issue_valid    - registered issue candidate present; issue_ready - accepted
//   issue_row      - row being issued
//   flush          - discard all entries
//   occupancy      - number of valid entries
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_ROWS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [NUM_ROWS-1:0]           disp_src_mask,
    output logic [$clog2(NUM_ROWS)-1:0]   disp_row,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [$clog2(NUM_ROWS)-1:0]   issue_row,
    input  logic                          flush,
    output logic [$clog2(NUM_ROWS):0]     occupancy
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int OCC_W = ROW_W + 1;

    sched_state_t          state_r, state_nxt_s;
    logic [NUM_ROWS-1:0]   valid_r, picked_r;
    logic                  issue_valid_r;
    logic [ROW_W-1:0]      issue_row_r;
    logic [OCC_W-1:0]      occupancy_r;
    logic [ROW_W-1:0]      flush_cnt_r;

    logic [ROW_W-1:0]      free_row_s, pick_row_s, free_idx_s;
    logic                  pick_found_s, disp_ready_s, alloc_s, issue_fire_s, refill_s;
    logic                  w_en_s, clear_en_s, free_en_s;
    logic [NUM_ROWS-1:0]   ready_vec_s, eligible_s, issuing_oh_s, alloc_oh_s;
    logic [NUM_ROWS-1:0]   set_lines_s, clear_lines_s;

    // Handshakes and allocation; a dispatch coinciding with flush is dropped.
    always_comb begin
        disp_ready_s = (state_r == RUN) && !(&valid_r);
        alloc_s      = disp_valid && disp_ready_s && !flush;
        issue_fire_s = issue_valid_r && issue_ready;
        refill_s     = !issue_valid_r || issue_fire_s;
        issuing_oh_s = issue_fire_s ? (NUM_ROWS'(1) << issue_row_r) : '0;
        alloc_oh_s   = alloc_s ? (NUM_ROWS'(1) << free_row_s) : '0;
        eligible_s   = valid_r & ready_vec_s & ~picked_r;
        // A producer issuing this cycle is already complete for the new op.
        set_lines_s  = disp_src_mask & valid_r & ~issuing_oh_s & ~(NUM_ROWS'(1) << free_row_s);
        w_en_s       = alloc_s;
    end

    // Lowest-index free row (scan downwards so the last hit is the lowest).
    always_comb begin
        free_row_s = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_row_s = ROW_W'(i);
            end else begin
                free_row_s = free_row_s;
            end
        end
    end

`ifdef SCHED_AGE_PRIORITY_EN
    logic [3:0] age_r [NUM_ROWS];
    logic [3:0] best_age_s;

    // Oldest eligible row; strict compare keeps ties on the lowest index.
    always_comb begin
        pick_found_s = 1'b0;
        pick_row_s   = '0;
        best_age_s   = 4'd0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (eligible_s[i] && (!pick_found_s || (age_r[i] > best_age_s))) begin
                pick_found_s = 1'b1;
                pick_row_s   = ROW_W'(i);
                best_age_s   = age_r[i];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Per-row saturating age: zeroed on allocation, counts while valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (rst) begin
                age_r[i] <= 4'd0;
            end else if (alloc_oh_s[i]) begin
                age_r[i] <= 4'd0;
            end else if (valid_r[i] && (age_r[i] != 4'hF)) begin
                age_r[i] <= age_r[i] + 4'd1;
            end else begin
                age_r[i] <= age_r[i];
            end
        end
    end
`else
    // Lowest-index eligible row.
    always_comb begin
        pick_found_s = |eligible_s;
        pick_row_s   = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (eligible_s[i]) begin
                pick_row_s = ROW_W'(i);
            end else begin
                pick_row_s = pick_row_s;
            end
        end
    end
`endif

    // Matrix maintenance: FLUSH sweeps one row per cycle (and clears every
    // column once); RUN frees/clears the row completing its issue handshake.
    always_comb begin
        if (state_r == FLUSH) begin
            free_en_s     = 1'b1;
            free_idx_s    = flush_cnt_r;
            clear_en_s    = (flush_cnt_r == ROW_W'(0));
            clear_lines_s = '1;
        end else begin
            free_en_s     = issue_fire_s;
            free_idx_s    = issue_row_r;
            clear_en_s    = issue_fire_s;
            clear_lines_s = issuing_oh_s;
        end
    end

    // Control FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (flush) state_nxt_s = FLUSH;
                else       state_nxt_s = RUN;
            end
            FLUSH: begin
                if (flush)                                     state_nxt_s = FLUSH;
                else if (flush_cnt_r == ROW_W'(NUM_ROWS - 1))  state_nxt_s = RUN;
                else                                           state_nxt_s = FLUSH;
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Entry bookkeeping, issue stage, occupancy and flush sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            valid_r       <= '0;
            picked_r      <= '0;
            issue_valid_r <= 1'b0;
            issue_row_r   <= '0;
            occupancy_r   <= '0;
            flush_cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (flush) begin
                valid_r       <= '0;
                picked_r      <= '0;
                issue_valid_r <= 1'b0;
                occupancy_r   <= '0;
                flush_cnt_r   <= '0;
            end else if (state_r == FLUSH) begin
                if (flush_cnt_r == ROW_W'(NUM_ROWS - 1)) flush_cnt_r <= '0;
                else                                     flush_cnt_r <= flush_cnt_r + ROW_W'(1);
            end else begin
                valid_r <= (valid_r & ~issuing_oh_s) | alloc_oh_s;
                if (refill_s && pick_found_s) begin
                    picked_r      <= (picked_r & ~issuing_oh_s) | (NUM_ROWS'(1) << pick_row_s);
                    issue_valid_r <= 1'b1;
                    issue_row_r   <= pick_row_s;
                end else if (refill_s) begin
                    picked_r      <= picked_r & ~issuing_oh_s;
                    issue_valid_r <= 1'b0;
                end else begin
                    picked_r      <= picked_r;
                end
                case ({alloc_s, issue_fire_s})
                    2'b10:   occupancy_r <= occupancy_r + OCC_W'(1);
                    2'b01:   occupancy_r <= occupancy_r - OCC_W'(1);
                    default: occupancy_r <= occupancy_r;
                endcase
            end
        end
    end

    issue_scheduler_dep_matrix #(.NUM_ROWS(NUM_ROWS)) u_dep_matrix (
        .clk            (clk),
        .rst            (rst),
        .w_en           (w_en_s),
        .w_row          (free_row_s),
        .set_lines      (set_lines_s),
        .clear_en       (clear_en_s),
        .clear_lines    (clear_lines_s),
        .free_en        (free_en_s),
        .free_row_index (free_idx_s),
        .ready_vector   (ready_vec_s)
    );

    assign disp_ready  = disp_ready_s;
    assign disp_row    = free_row_s;
    assign issue_valid = issue_valid_r;
    assign issue_row   = issue_row_r;
    assign occupancy   = occupancy_r;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: randomized stimulus against a behavioural scheduler
// model (entry sets, per-entry wait sets, oldest/lowest selection).
module tb_issue_scheduler;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       disp_valid = 1'b0;
    logic       disp_ready;
    logic [7:0] disp_src_mask = 8'h00;
    logic [2:0] disp_row;
    logic       issue_valid;
    logic       issue_ready = 1'b0;
    logic [2:0] issue_row;
    logic       flush = 1'b0;
    logic [3:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [7:0] m_valid;
    logic [7:0] m_picked;
    logic [7:0] m_wait [N];
    int         m_age  [N];
    bit         m_iv;
    int         m_ir;
    int         m_occ;
    bit         m_flushing;
    int         m_fcnt;

    issue_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_src_mask (disp_src_mask),
        .disp_row      (disp_row),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_row     (issue_row),
        .flush         (flush),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int choose(input logic [7:0] elig);
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
`ifdef SCHED_AGE_PRIORITY_EN
                if (best < 0 || m_age[i] > m_age[best]) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_valid = 8'h00; m_picked = 8'h00; m_iv = 1'b0; m_ir = 0; m_occ = 0;
        m_flushing = 1'b0; m_fcnt = 0;
        for (int i = 0; i < N; i++) begin m_wait[i] = 8'h00; m_age[i] = 0; end
    endtask

    task automatic model_step(input bit dv, input logic [7:0] mask, input bit ir, input bit fl);
        logic [7:0] elig, iss_oh, valid_old;
        int  drow, cand;
        bit  dfire, ifire;
        drow  = first_free();
        dfire = dv && !m_flushing && (drow >= 0);
        ifire = m_iv && ir;
        for (int i = 0; i < N; i++) elig[i] = m_valid[i] && (m_wait[i] == 8'h00) && !m_picked[i];
        cand      = choose(elig);
        iss_oh    = ifire ? (8'h01 << m_ir) : 8'h00;
        valid_old = m_valid;
        for (int i = 0; i < N; i++) if (valid_old[i] && m_age[i] < 15) m_age[i]++;
        if (fl) begin
            m_valid = 8'h00; m_picked = 8'h00; m_iv = 1'b0; m_occ = 0;
            m_flushing = 1'b1; m_fcnt = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 8'h00;
        end else if (m_flushing) begin
            if (m_fcnt == N - 1) begin m_flushing = 1'b0; m_fcnt = 0; end
            else m_fcnt++;
        end else begin
            if (ifire) begin
                m_valid[m_ir]  = 1'b0;
                m_picked[m_ir] = 1'b0;
                for (int i = 0; i < N; i++) m_wait[i][m_ir] = 1'b0;
                m_occ--;
            end
            if (dfire) begin
                m_wait[drow]  = mask & valid_old & ~iss_oh & ~(8'h01 << drow);
                m_valid[drow] = 1'b1;
                m_age[drow]   = 0;
                m_occ++;
            end
            if (!m_iv || ifire) begin
                if (cand >= 0) begin m_iv = 1'b1; m_ir = cand; m_picked[cand] = 1'b1; end
                else m_iv = 1'b0;
            end
        end
    endtask

    // Called at a negedge: check outputs, drive inputs, advance model, wait one cycle.
    task automatic cycle(input bit dv, input logic [7:0] mask, input bit ir, input bit fl);
        bit exp_dr;
        exp_dr = !m_flushing && (m_valid != 8'hFF);
        check_eq("disp_ready", disp_ready, exp_dr);
        if (exp_dr) check_eq("disp_row", disp_row, first_free());
        check_eq("issue_valid", issue_valid, m_iv);
        if (m_iv) check_eq("issue_row", issue_row, m_ir);
        check_eq("occupancy", occupancy, m_occ);
        disp_valid = dv; disp_src_mask = mask; issue_ready = ir; flush = fl;
        model_step(dv, mask, ir, fl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; disp_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0; disp_src_mask = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_phase(input int cycles, input int p_disp, input int p_iss, input int p_flush);
        for (int c = 0; c < cycles; c++) begin
            cycle($urandom_range(99) < p_disp, 8'($urandom),
                  $urandom_range(99) < p_iss, $urandom_range(999) < p_flush);
        end
    endtask

    initial begin
        do_reset();
        // Row 0 (no deps), row 1 depending on row 0, then drain.
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        // Fill to capacity with issue stalled, then release one issue.
        run_phase(16, 100, 0, 0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        run_phase(4, 100, 0, 0);
        // Flush with entries present, let the sweep complete.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        run_phase(10, 100, 0, 0);
        // Mixed random traffic.
        run_phase(300, 70, 60, 0);
        run_phase(400, 50, 50, 20);
        run_phase(300, 90, 90, 5);
        // Reset in the middle of traffic, then continue.
        do_reset();
        run_phase(300, 60, 60, 10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_ROWS, default CORE_PKG::SCHED_ROWS (8), scheduler entries = dependency-matrix rows.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 disp_valid  in  1  dispatch request.
REQ-005 disp_ready  out  1  dispatch accepted when disp_valid&&disp_ready.
REQ-006 disp_src_mask  in  NUM_ROWS  rows the dispatched op depends on.
REQ-007 disp_row  out  clog2(NUM_ROWS)  row allocated to the dispatched op, valid with disp_ready.
REQ-008 issue_valid  out  1  registered issue candidate present.
REQ-009 issue_ready  in  1  consumer accepts issue.
REQ-010 issue_row  out  clog2(NUM_ROWS)  row being issued.
REQ-011 flush  in  1  discard all entries.
REQ-012 occupancy  out  clog2(NUM_ROWS)+1  count of valid entries.

Function
REQ-013 SHALL hold valid[NUM_ROWS], picked[NUM_ROWS] bitmaps; free rows = ~valid.
REQ-014 disp_ready SHALL be 1 iff state==RUN and any row free; disp_row = lowest-index free row.
REQ-015 On dispatch handshake SHALL write matrix row disp_row (w_en) with set_lines = disp_src_mask & valid & ~issuing_onehot & ~(1<<disp_row); set valid[disp_row] next edge.
REQ-016 A row freed by issue in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-017 Eligible rows = valid & ready_vector & ~picked; dispatched op eligible earliest one cycle after its write.
REQ-018 Select SHALL register one eligible row into issue stage (1-cycle latency), setting picked; issue_valid/issue_row held stable until issue_ready.
REQ-019 On issue handshake SHALL, same cycle, drive free_en/free_row_index=issue_row and clear_en with clear_lines = one-hot issue_row; clear valid/picked bits; refill stage from eligible rows next edge (back-to-back issue allowed).
REQ-020 occupancy: +1 dispatch, -1 issue, unchanged on both, never wraps.
REQ-021 FSM states RUN, FLUSH; RUN->FLUSH on flush; FLUSH->RUN after flush_cnt==NUM_ROWS-1; flush in FLUSH restarts flush_cnt at 0.
REQ-022 On flush edge SHALL clear valid, picked, issue stage, occupancy; flush wins over same-cycle dispatch (dropped); a same-cycle issue handshake completes.
REQ-023 In FLUSH SHALL free row flush_cnt each cycle, drive clear_en with all-ones clear_lines on first FLUSH cycle, hold disp_ready=0, issue_valid=0.

Reset
REQ-024 rst SHALL give state=RUN, valid=0, picked=0, issue_valid=0, issue_row=0, occupancy=0, flush_cnt=0, disp_row=0; matrix reset with same rst.
REQ-025 rst mid-operation SHALL abandon in-flight issue without free/clear pulses.

Configuration
REQ-026 Macro SCHED_AGE_PRIORITY_EN defined: per-row 4-bit saturating age counter, zeroed on allocation, +1 per cycle while valid; select oldest eligible, ties lowest index.
REQ-027 Macro undefined: select lowest-index eligible row; no age counters.

Structure
REQ-028 CORE_PKG SHALL hold SCHED_ROWS, sched_row_t index typedef, sched_state_t enum {RUN, FLUSH}.
REQ-029 SHALL instantiate exactly one DependencyMatrix (NUM_ROWS x NUM_ROWS), driven only by this block.

Verification
REQ-030 Reset, dispatch rows 0 (mask 0) and 1 (mask 8'b00000001) -> disp_row 0 then 1; row 0 issues 2 cycles after dispatch; row 1 issues only after row 0 handshake.
REQ-031 Fill 8 entries, issue_ready=0 -> disp_ready=0, occupancy=8, issue_row stable; one issue -> row freed, disp_ready=1 next cycle.
REQ-032 Dispatch with mask on row being issued same cycle -> new entry not blocked, eligible next cycle.
REQ-033 Flush with 5 valid entries -> issue_valid=0 next cycle, free_row_index 0..7 over 8 cycles, occupancy=0, disp_ready=1 in cycle 9.
REQ-034 Rows 2 and 5 both ready, 5 allocated first -> with SCHED_AGE_PRIORITY_EN row 5 issues first; without, row 2.
